// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin arbiter with bounded lock sharing one 16x32 register file port
module regfile_port_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [4*NREQ-1:0]    a1,
    input  logic [4*NREQ-1:0]    a2,
    input  logic [4*NREQ-1:0]    a3,
    input  logic [32*NREQ-1:0]   wd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [31:0]          rd1,
    output logic [31:0]          rd2,
    output logic                 wr_r15_err,
    output logic [3:0]           rf_a1,
    output logic [3:0]           rf_a2,
    output logic [3:0]           rf_a3,
    output logic [31:0]          rf_wd3,
    output logic                 rf_we,
    input  logic [31:0]          rf_rd1,
    input  logic [31:0]          rf_rd2
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = ($clog2(MAX_LOCK + 1) < 3) ? 3 : $clog2(MAX_LOCK + 1);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic          owner_vld;
    logic [CW-1:0] lock_cnt;

    logic [3:0]    last_a1, last_a2, last_a3;
    logic [31:0]   last_wd;

    logic          gnt_any;
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic [CW:0]   cnt_next;
    logic          keep_lock;
    logic [PW-1:0] rr_next;

    // Pick the winner: a live lock owner pins the port, otherwise scan from rr_ptr with wrap
    always_comb begin
        gnt_any = 1'b0;
        win     = '0;
        cand    = '0;
        if (reset) begin
            gnt_any = 1'b0;
        end else if (owner_vld && (lock_cnt < CW'(MAX_LOCK))) begin
            if (req[owner]) begin
                gnt_any = 1'b1;
                win     = owner;
            end
        end else begin
            // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = PW'((int'(rr_ptr) + k) % NREQ);
                if (req[cand]) begin
                    gnt_any = 1'b1;
                    win     = cand;
                end
            end
        end
    end

    // Drive the regfile port from the winner; idle cycles hold the last addresses
    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[win] = 1'b1;
        end
        rf_a1     = gnt_any ? a1[4*win +: 4]   : last_a1;
        rf_a2     = gnt_any ? a2[4*win +: 4]   : last_a2;
        rf_a3     = gnt_any ? a3[4*win +: 4]   : last_a3;
        rf_wd3    = gnt_any ? wd[32*win +: 32] : last_wd;
        rf_we     = gnt_any & we[win];
        cnt_next  = {1'b0, lock_cnt} + (CW+1)'(1);
        keep_lock = lock[win] && (cnt_next < (CW+1)'(MAX_LOCK));
        rr_next   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end

    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;

    // Arbitration state: lock ownership, bounded hold count and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            lock_cnt  <= '0;
        end else if (gnt_any) begin
            if (keep_lock) begin
                owner     <= win;
                owner_vld <= 1'b1;
                lock_cnt  <= cnt_next[CW-1:0];
            end else begin
                owner_vld <= 1'b0;
                lock_cnt  <= '0;
                rr_ptr    <= rr_next;
            end
        end else if (owner_vld && !req[owner]) begin
            owner_vld <= 1'b0;
            lock_cnt  <= '0;
        end
    end

    // Remember the last issued op so the regfile inputs stay stable while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_a1 <= '0;
            last_a2 <= '0;
            last_a3 <= '0;
            last_wd <= '0;
        end else if (gnt_any) begin
            last_a1 <= rf_a1;
            last_a2 <= rf_a2;
            last_a3 <= rf_a3;
            last_wd <= rf_wd3;
        end
    end

    // Align valid and the R15 write error with the regfile's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid     <= '0;
            wr_r15_err <= 1'b0;
        end else begin
            rvalid     <= gnt;
            wr_r15_err <= rf_we && (rf_a3 == 4'hF);
        end
    end

endmodule
